// File: rtl/led_axi_lite_slave.sv
// AXI4-Lite slave with four 32-bit registers (LED_DATA, CTRL, PERIOD, SCRATCH) driving an LED bank.
// Define LED_BLINK_EN to add the blink engine (CTRL[0] enables, PERIOD sets the half-period).
module led_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            led
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid, once raised, is held with stable payload until that edge.
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} r_state_e;

  w_state_e                        w_state_q, w_state_d;
  r_state_e                        r_state_q, r_state_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0]   regs_d [4];
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [LED_WIDTH-1:0]            led_q, led_d;
  logic [1:0]                      wr_idx, rd_idx;
  logic                            wr_fire;
  logic                            unused_bits;

  assign wr_idx      = S_AXI_AWADDR[3:2];
  assign rd_idx      = S_AXI_ARADDR[3:2];
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    w_state_d = w_state_q;
    wr_fire   = 1'b0;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = W_ACCEPT;
      W_ACCEPT: begin
        wr_fire   = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP:   if (S_AXI_BREADY) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
    if (wr_fire) begin
      for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
        if (S_AXI_WSTRB[i]) regs_d[wr_idx][8*i +: 8] = S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // RDATA samples the registers before this edge's write lands, so a colliding read sees old data.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE:   if (S_AXI_ARVALID) r_state_d = R_ACCEPT;
      R_ACCEPT: begin
        rdata_d   = regs_q[rd_idx];
        r_state_d = R_RESP;
      end
      R_RESP:   if (S_AXI_RREADY) r_state_d = R_IDLE;
      default:  r_state_d = R_IDLE;
    endcase
  end

`ifdef LED_BLINK_EN
  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!regs_q[1][0]) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wr_fire && wr_idx == 2'd2) begin
      cnt_d = '0;
    end else if (cnt_q == regs_q[2]) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign led_d = regs_q[0][LED_WIDTH-1:0] ^ {LED_WIDTH{phase_q}};
`else
  assign led_d = regs_q[0][LED_WIDTH-1:0];
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      regs_q    <= '{default: '0};
      rdata_q   <= '0;
      led_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      regs_q    <= regs_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
    end
  end

  assign S_AXI_AWREADY = (w_state_q == W_ACCEPT);
  assign S_AXI_WREADY  = (w_state_q == W_ACCEPT);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = (r_state_q == R_ACCEPT);
  assign S_AXI_RVALID  = (r_state_q == R_RESP);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign led           = led_q;

endmodule

// File: tb/tb_led_axi_lite_slave.sv
// Self-checking bench for led_axi_lite_slave: directed scenarios, then random traffic against a register model.
// Build with +define+LED_BLINK_EN to exercise the blink engine as well.
module tb_led_axi_lite_slave;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  led;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  led_axi_lite_slave dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .led(led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (start and end just after a rising edge)
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_delay);
    int n;
    awaddr = addr; awprot = 3'($urandom); wdata = data; wstrb = strb; awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge aclk); check("aw_waits_for_w", awready, 1'b0);
      @(posedge aclk); #1;
    end
    wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 20);
    check("aw_latency", n, 2);
    check("w_ready_with_aw", wready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge aclk); check("b_held", bvalid, 1'b1);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    @(negedge aclk); check("b_latency", bvalid, 1'b1);
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_delay, output logic [31:0] data);
    int n;
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    check("ar_latency", n, 2);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < r_delay; i++) begin
      @(negedge aclk); check("r_held", rvalid, 1'b1);
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(negedge aclk); check("r_latency", rvalid, 1'b1);
    data = rdata;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  // ---------------- behavioural model + scoreboard, compared every cycle mid-period
  logic [31:0] mem [4];
  logic [31:0] exp_q[$];
  logic [3:0]  led_exp;
  logic [31:0] r_hold;
  logic [1:0]  m_idx;
  logic        m_phase, m_en, m_restart;
  bit          model_ok = 0;
  bit          r_stall = 0;
  bit          b_stall = 0;
  int          b_pending = 0;
`ifdef LED_BLINK_EN
  int          blink_j = 0;
  logic        base_phase = 1'b0;
`endif

  always @(negedge aclk) begin
    if (model_ok) begin
      check("led", led, led_exp);
      if (r_stall) begin
        check("rvalid_stable", rvalid, 1'b1);
        check("rdata_stable", rdata, r_hold);
      end
      if (b_stall) check("bvalid_stable", bvalid, 1'b1);
      if (awready || wready) check("aw_w_ready_together", wready, awready);
      if (rvalid) check("rresp", rresp, 2'b00);
      if (bvalid) check("bresp", bresp, 2'b00);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check("r_unexpected", 1'b1, 1'b0);
        else check("rdata", rdata, exp_q.pop_front());
      end
      if (bvalid && bready) begin
        if (b_pending == 0) check("b_unexpected", 1'b1, 1'b0);
        else b_pending--;
      end
    end
    r_stall = model_ok && rvalid && !rready && !areset;
    b_stall = model_ok && bvalid && !bready && !areset;
    r_hold  = rdata;
    if (areset) begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      exp_q.delete();
      b_pending = 0;
      led_exp   = '0;
`ifdef LED_BLINK_EN
      blink_j    = 0;
      base_phase = 1'b0;
`endif
      model_ok = 1;
    end else if (model_ok) begin
      m_en = mem[1][0];
`ifdef LED_BLINK_EN
      m_phase = base_phase ^ 1'((longint'(blink_j) / (longint'(mem[2]) + 64'd1)) & 64'd1);
`else
      m_phase = 1'b0;
`endif
      led_exp = mem[0][3:0] ^ {4{m_phase}};
      if (arvalid && arready) exp_q.push_back(mem[araddr[3:2]]);
      m_restart = 1'b0;
      if (awvalid && awready && wvalid && wready) begin
        m_idx = awaddr[3:2];
        for (int i = 0; i < 4; i++) if (wstrb[i]) mem[m_idx][8*i +: 8] = wdata[8*i +: 8];
        b_pending++;
        m_restart = (m_idx == 2'd2);
      end
`ifdef LED_BLINK_EN
      if (!m_en) begin
        blink_j = 0; base_phase = 1'b0;
      end else if (m_restart) begin
        base_phase = m_phase; blink_j = 0;
      end else begin
        blink_j++;
      end
`else
      if (m_en && m_restart) m_idx = 2'd0;
`endif
    end
  end

  // ---------------- stimulus
  initial begin
    logic [31:0] rd;
    logic [31:0] rnd_data;
    logic [3:0]  rnd_addr, rnd_raddr, rnd_strb;
    int          n, sel, lead, dly;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_led", led, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {bresp, rresp}, 4'h0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // full-strobe write/read
    axi_write(4'h0, 32'h0101_FFFF, 4'hF, 0, 0);
    check("led_after_first_write", led, 4'hF);
    axi_write(4'h4, 32'hABCD_0001, 4'hF, 0, 0);
    axi_write(4'h8, 32'hDEAD_0011, 4'hF, 0, 0);
    axi_write(4'hC, 32'hBEEF_0011, 4'hF, 0, 0);
    axi_read(4'h0, 0, rd); check("full_rd_0", rd, 32'h0101_FFFF);
    axi_read(4'h4, 0, rd); check("full_rd_4", rd, 32'hABCD_0001);
    axi_read(4'h8, 1, rd); check("full_rd_8", rd, 32'hDEAD_0011);
    axi_read(4'hC, 2, rd); check("full_rd_c", rd, 32'hBEEF_0011);

    // byte strobes
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(4'hC, 32'hABCD_0001, 4'h3, 0, 0);
    axi_read(4'hC, 0, rd); check("strobe_rd", rd, 32'hFFFF_0001);
    axi_write(4'hC, 32'h1234_5678, 4'h0, 0, 1);
    axi_read(4'hE, 0, rd); check("zero_strobe_rd", rd, 32'hFFFF_0001);

    // AW three cycles ahead of W
    axi_write(4'h0, 32'h0000_0006, 4'hF, 3, 0);

    // write backpressure with a second write pending
    awaddr = 4'h4; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 20);
    check("bp_aw_latency", n, 2);
    @(posedge aclk); #1;
    awaddr = 4'h8; wdata = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_bvalid", bvalid, 1'b1);
      check("bp_bresp", bresp, 2'b00);
      check("bp_awready", awready, 1'b0);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    @(negedge aclk); check("bp_awready_hs", awready, 1'b0);
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk); check("bp_awready_idle", awready, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk); check("bp_awready_second", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge aclk); check("bp_bvalid_second", bvalid, 1'b1);
    @(posedge aclk); #1;
    bready = 1'b0;
    axi_read(4'h4, 0, rd); check("bp_rd_4", rd, 32'h1111_2222);
    axi_read(4'h8, 0, rd); check("bp_rd_8", rd, 32'h3333_4444);

    // reset while a read response is stalled
    araddr = 4'h4; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    check("rr_ar_latency", n, 2);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk); check("rr_rvalid_before", rvalid, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rr_rvalid_after", rvalid, 1'b0);
    check("rr_rdata_after", rdata, 32'h0);
    check("rr_led_after", led, 4'h0);
    @(posedge aclk); #1;
    for (int a = 0; a < 4; a++) begin
      axi_read(4'(a * 4), 0, rd); check("rr_reg_zero", rd, 32'h0);
    end
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    axi_read(4'h0, 0, rd); check("first_after_reset", rd, 32'h0);

`ifdef LED_BLINK_EN
    axi_write(4'h0, 32'h5, 4'hF, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0);
    axi_write(4'h4, 32'h1, 4'hF, 0, 0);
    n = 0;
    do begin @(negedge aclk); n++; end while (led !== 4'hA && n < 12);
    check("blink_first_toggle", n < 12, 1'b1);
    for (int k = 0; k < 3; k++) begin @(negedge aclk); check("blink_a1", led, 4'hA); end
    for (int k = 0; k < 4; k++) begin @(negedge aclk); check("blink_5", led, 4'h5); end
    for (int k = 0; k < 4; k++) begin @(negedge aclk); check("blink_a2", led, 4'hA); end
    @(posedge aclk); #1;
    axi_write(4'h4, 32'h0, 4'hF, 0, 0);
    @(posedge aclk); #1;
    for (int k = 0; k < 6; k++) begin @(negedge aclk); check("blink_off", led, 4'h5); end
    @(posedge aclk); #1;
`endif

    // random traffic, including colliding reads and writes
    for (int it = 0; it < 60; it++) begin
      rnd_addr  = 4'($urandom_range(0, 15));
      rnd_raddr = 4'($urandom_range(0, 15));
      rnd_data  = $urandom;
      rnd_strb  = 4'($urandom_range(0, 15));
      lead      = $urandom_range(0, 3);
      dly       = $urandom_range(0, 2);
      sel       = $urandom_range(0, 2);
      if (sel == 0) begin
        axi_write(rnd_addr, rnd_data, rnd_strb, lead, dly);
      end else if (sel == 1) begin
        axi_read(rnd_raddr, dly, rd);
      end else begin
        fork
          axi_write(rnd_addr, rnd_data, rnd_strb, 0, dly);
          axi_read(rnd_addr, lead, rd);
        join
      end
    end

    repeat (2) @(posedge aclk);
    check("r_queue_drained", exp_q.size(), 0);
    check("b_all_answered", b_pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_axi_lite_slave.md
LED_AXI_LITE_SLAVE -- requirements
Module: led_axi_lite_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, SHALL set the byte-address width; bits [3:2] select the register, and bits [1:0] are ignored.
REQ-003 Parameter LED_WIDTH, default 4, SHALL set the LED output width (1..32).
REQ-004 One clock; reset is synchronous and active-high. Clock and reset SHALL be the first two ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous active-high reset.
REQ-005 Write ports SHALL be:
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1.
- S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1.
- S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2.
- S_AXI_BVALID  out  1.
- S_AXI_BREADY  in  1.
- AWPROT is ignored.
REQ-006 Read ports SHALL be:
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1.
- S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32.
- S_AXI_RRESP  out  2.
- S_AXI_RVALID  out  1.
- S_AXI_RREADY  in  1.
- ARPROT is ignored.
REQ-007 Port led  out  LED_WIDTH SHALL be the registered LED drive.

Function
REQ-008 The block SHALL hold four 32-bit read/write registers:
- 0x0 LED_DATA.
- 0x4 CTRL (bit0 = blink_en).
- 0x8 PERIOD.
- 0xC SCRATCH.
REQ-009 The write FSM SHALL have states W_IDLE, W_ACCEPT and W_RESP:
- W_IDLE -> W_ACCEPT when AWVALID && WVALID are both sampled high; AW/W arriving in either order wait in W_IDLE.
- In W_ACCEPT, AWREADY and WREADY are high for exactly one cycle, and the register is updated at that edge.
- W_ACCEPT -> W_RESP, with BVALID=1 and BRESP=00.
- W_RESP -> W_IDLE on BVALID && BREADY.
REQ-010 Write latency: AWREADY/WREADY SHALL rise 1 cycle after both valids are sampled, and BVALID 2 cycles after.
REQ-011 Each byte lane i SHALL be written only if WSTRB[i]=1; WSTRB=0 SHALL leave the register unchanged and still return OKAY.
REQ-012 The read FSM SHALL have states R_IDLE, R_ACCEPT and R_RESP:
- R_IDLE -> R_ACCEPT when ARVALID is sampled high.
- In R_ACCEPT, ARREADY is high for one cycle and RDATA is captured from the addressed register.
- R_ACCEPT -> R_RESP, with RVALID=1 and RRESP=00.
- R_RESP -> R_IDLE on RVALID && RREADY.
- Read latency: RVALID rises 2 cycles after ARVALID is sampled.
REQ-013 While BVALID or RVALID is held (ready low), the corresponding channel SHALL accept no new address, and RDATA/BRESP SHALL stay stable.
REQ-014 The read and write FSMs SHALL be independent; a read capturing the same register in the same cycle as a write SHALL return the pre-write value.
REQ-015 BRESP and RRESP SHALL always be OKAY (00); SLVERR/DECERR are never issued.
REQ-016 Without blinking, led SHALL equal LED_DATA[LED_WIDTH-1:0], registered with one cycle of delay after the write edge.

Reset
REQ-017 While ARESET=1 at a rising edge, the block SHALL:
- clear all registers to 0;
- return both FSMs to idle;
- drive AWREADY, WREADY, BVALID, ARREADY, RVALID and led to 0, and RDATA, BRESP and RRESP to 0.
REQ-018 Reset asserted mid-transaction SHALL abort it without a response; the master restarts after reset.
REQ-019 The first transaction SHALL be accepted on the first cycle after ARESET is deasserted.

Configuration
REQ-020 Macro LED_BLINK_EN SHALL control the blink function.
REQ-021 With LED_BLINK_EN defined, the block SHALL include a 32-bit blink counter and a phase bit:
- When blink_en=1, the counter counts 0..PERIOD and then wraps to 0 while toggling phase.
- led = LED_DATA[LED_WIDTH-1:0] XOR {LED_WIDTH{phase}}.
- PERIOD=0 toggles phase every cycle.
- blink_en=0 clears the counter and phase.
- Writing PERIOD restarts the counter at 0.
REQ-022 Without LED_BLINK_EN, the block SHALL have no counter: led follows REQ-016, and CTRL and PERIOD remain plain storage.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Full-strobe write/read: write 0x0101FFFF, 0xabcd0001, 0xdead0011 and 0xbeef0011 to 0x0, 0x4, 0x8 and 0xC, each with WSTRB=F. Each read returns the same value with OKAY; led=0xF after the first write.
- Byte strobes: write 0xFFFFFFFF to 0xC, then write 0xabcd0001 with WSTRB=0011. Read returns 0xFFFF0001.
- Channel ordering: AWVALID is presented 3 cycles before WVALID. AWREADY and WREADY pulse together exactly 1 cycle after WVALID, and BVALID follows 1 cycle later.
- Write backpressure: BREADY held low for 5 cycles with a second AW/W pending. BVALID and BRESP stay stable, and AWREADY stays 0 until the cycle after the BREADY handshake.
- Read/reset: ARVALID issued, then ARESET asserted in R_RESP with RREADY=0. RVALID=0 and all registers read 0x00000000 after reset.
- Blink (LED_BLINK_EN): LED_DATA=0x5, PERIOD=3, CTRL=1. led alternates 0x5 and 0xA every 4 cycles; after CTRL=0, led holds 0x5.
